// File: rtl/plp_rom_prefetch_pkg.sv
// plp_rom_prefetch_pkg
// Shared types and default constants for the boot-ROM instruction prefetcher.
//   state_t  : prefetch control states (IDLE after reset, FETCH forever after)
//   entry_t  : one buffered instruction word together with its byte PC
//   DEF_*    : default values for the ADDR_W / DEPTH / RESET_PC parameters
//   align_pc : forces a byte PC onto a word boundary
package plp_rom_prefetch_pkg;

  localparam int          DEF_ADDR_W   = 9;
  localparam int          DEF_DEPTH    = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  // Redirect targets may carry byte-offset bits; the ROM is word addressed.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/plp_rom_prefetch_if.sv
// plp_rom_prefetch_if
// Bundles the prefetcher's three external channels:
//   redirect : redirect_valid, redirect_pc      (CPU -> prefetcher)
//   rom      : rom_en, rom_addr -> / <- rom_data (prefetcher <-> ROM port)
//   output   : out_valid, out_instr, out_pc -> / <- out_ready (prefetcher <-> CPU)
// Modports:
//   master : the prefetch block itself
//   slave  : the environment (CPU fetch path plus ROM)
interface plp_rom_prefetch_if
  import plp_rom_prefetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;

  modport master (
    input  redirect_valid, redirect_pc, rom_data, out_ready,
    output rom_en, rom_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, rom_data, out_ready,
    input  rom_en, rom_addr, out_valid, out_instr, out_pc
  );

endinterface

// File: rtl/plp_sync_fifo.sv
// plp_sync_fifo
// Small synchronous FIFO of entry_t with a registered head, so the consumer
// sees the oldest entry straight from flops.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous flush, dominates push and pop
//   push        : write push_data (accepted when not full, or full with pop)
//   push_data   : entry to enqueue
//   pop         : drop the current head (ignored when empty)
//   head        : oldest entry, zero when empty
//   head_valid  : FIFO holds at least one entry
//   count       : current occupancy, 0..DEPTH
module plp_sync_fifo
  import plp_rom_prefetch_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          head_valid,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  entry_t        head_q;
  entry_t        head_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_d;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push_ok;
  logic          pop_ok;

  // Next read pointer, occupancy and head value. The new head is either the
  // word arriving this cycle (when it lands in the slot that becomes the
  // head) or the stored entry at the advanced read pointer.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = '0;
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
    if (count_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_data;
      end else begin
        head_d = mem[rd_ptr_d];
      end
    end
  end

  // Pointer, occupancy and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign head       = head_q;
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/plp_rom_prefetch.sv
// plp_rom_prefetch
// Instruction prefetch stage between the dual-port boot ROM and the CPU fetch
// path. Issues sequential word reads, buffers returned words with their PCs
// and hands them to the CPU over valid/ready; redirects flush the buffer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (master) : redirect_valid/redirect_pc in, rom_en/rom_addr out,
//                  rom_data in, out_valid/out_instr/out_pc out, out_ready in
//   stat_fetches : ROM reads issued, saturating    (ROM_PREFETCH_STATS_EN only)
//   stat_flushes : redirects accepted, saturating  (ROM_PREFETCH_STATS_EN only)
// Build option: define ROM_PREFETCH_STATS_EN to add the statistics counters.
module plp_rom_prefetch
  import plp_rom_prefetch_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          DEPTH    = DEF_DEPTH,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  plp_rom_prefetch_if.master  bus
`ifdef ROM_PREFETCH_STATS_EN
  ,
  output logic [15:0]         stat_fetches,
  output logic [15:0]         stat_flushes
`endif
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_V = (CW + 1)'(DEPTH);

  state_t        state_q;
  state_t        state_d;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   issued_pc_q;
  logic          inflight_q;
  logic          rom_en;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          push;
  logic          pop;
  logic          head_valid;
  entry_t        push_data;
  entry_t        head;

  // Slots already spoken for: buffered words plus the read whose data is on
  // rom_data this cycle. Issuing only below DEPTH means a capture can never
  // find the FIFO full without a matching pop.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and ROM issue decision. A redirect blocks issue in its own
  // cycle because fetch_pc still holds the old path.
  always_comb begin
    state_d = state_q;
    rom_en  = 1'b0;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   rom_en  = !bus.redirect_valid && (occupancy < DEPTH_V);
      default: state_d = IDLE;
    endcase
  end

  // Fetch PC, PC of the outstanding read, and the in-flight flag. The flag
  // is simply last cycle's issue: data always returns one edge later, so
  // capture and the next issue share that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      inflight_q <= rom_en;
      if (rom_en) begin
        issued_pc_q <= fetch_pc_q;
      end
      if (bus.redirect_valid) begin
        fetch_pc_q <= align_pc(bus.redirect_pc);
      end else if (rom_en) begin
        fetch_pc_q <= fetch_pc_q + 32'd4;
      end
    end
  end

  // A redirect squashes the word returning this cycle (issued last cycle).
  assign push            = inflight_q && !bus.redirect_valid;
  assign push_data.instr = bus.rom_data;
  assign push_data.pc    = issued_pc_q;
  assign pop             = head_valid && bus.out_ready;

  plp_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (bus.redirect_valid),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  // rom_addr wraps at the ROM size while fetch_pc keeps counting.
  assign bus.rom_en    = rom_en;
  assign bus.rom_addr  = fetch_pc_q[ADDR_W+1:2];
  assign bus.out_valid = head_valid;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;

`ifdef ROM_PREFETCH_STATS_EN
  // Saturating counters of issued ROM reads and accepted redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetches <= '0;
      stat_flushes <= '0;
    end else begin
      if (rom_en && (stat_fetches != 16'hFFFF)) begin
        stat_fetches <= stat_fetches + 16'd1;
      end
      if (bus.redirect_valid && (stat_flushes != 16'hFFFF)) begin
        stat_flushes <= stat_flushes + 16'd1;
      end
    end
  end
`endif

endmodule
